// File: rtl/instruction_memory_if.sv
// Fetch port between the PC stage and the instruction ROM.
// master drives PC; slave returns the registered word and PC + 4.
interface instruction_memory_if;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] PC_Out;

  modport master (
    output PC,
    input  Instruction,
    input  PC_Out
  );

  modport slave (
    input  PC,
    output Instruction,
    output PC_Out
  );
endinterface

// File: rtl/instruction_memory.sv
// Byte-addressed big-endian instruction ROM with one-cycle fetch.
// Registers the fetched word and the next sequential PC.
module instruction_memory #(
  parameter int MEM_BYTES = 64
) (
  input logic                  clk,
  input logic                  reset,
  instruction_memory_if.slave  bus
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  function automatic logic [31:0] image_word(input int unsigned w);
    case (w)
      0:       return 32'h00221820;
      1:       return 32'h00222022;
      2:       return 32'h00222824;
      3:       return 32'h00223025;
      4:       return 32'h0022382A;
      5:       return 32'h00224027;
      6:       return 32'h00644820;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [7:0] image_byte(input int unsigned i);
    logic [31:0] w;
    w = image_word(i / 4);
    case (i % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Image is constant, so it is present from elaboration and
  // no fetch address (even X/Z) can disturb it.
  logic [7:0] mem [MEM_BYTES];

  for (genvar g = 0; g < MEM_BYTES; g++) begin : g_rom
    assign mem[g] = image_byte(g);
  end

  logic [31:0]   addr;
  logic [AW-1:0] idx;
  logic          in_range;
  logic [31:0]   fetch_word;

  assign addr     = {bus.PC[31:2], 2'b00};
  assign idx      = addr[AW-1:0];
  assign in_range = ({1'b0, addr} + 33'd3) < LIMIT;

  always_comb begin
    fetch_word = 32'h0;
    if (in_range) begin
      fetch_word = {mem[idx],
                    mem[idx + AW'(1)],
                    mem[idx + AW'(2)],
                    mem[idx + AW'(3)]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Instruction <= 32'h0;
      bus.PC_Out      <= 32'h0;
    end else begin
      bus.Instruction <= fetch_word;
      bus.PC_Out      <= bus.PC + 32'd4;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory.
// Expected words come from a bench-side copy of the program image.
module tb_instruction_memory;

  logic clk = 1'b0;
  logic reset;

  instruction_memory_if bus ();

  instruction_memory #(.MEM_BYTES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_out;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] model(input logic [31:0] pc);
    logic [31:0] img [7];
    logic [31:0] a;
    img = '{32'h00221820, 32'h00222022, 32'h00222824, 32'h00223025,
            32'h0022382A, 32'h00224027, 32'h00644820};
    a = {pc[31:2], 2'b00};
    if (a < 32'd28) return img[a[4:2]];
    return 32'h0;
  endfunction

  task automatic issue(input logic r, input logic [31:0] pc,
                       input logic [31:0] ei, input logic [31:0] ep);
    @(negedge clk);
    reset  = r;
    bus.PC = pc;
    sb.push_back('{ei, ep});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    issue(1'b1, 32'h10, 32'h0, 32'h0);
    e = sb.pop_front();
    checks += 2;
    if (bus.Instruction !== e.instr) begin
      errors++;
      $display("FAIL reset instr: got %h want %h", bus.Instruction, e.instr);
    end
    if (bus.PC_Out !== e.pc_out) begin
      errors++;
      $display("FAIL reset pc_out: got %h want %h", bus.PC_Out, e.pc_out);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want [7];
    want = '{32'h00221820, 32'h00222022, 32'h00222824, 32'h00223025,
             32'h0022382A, 32'h00224027, 32'h00644820};
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, 32'(i * 4), want[i], 32'(i * 4 + 4));
      e = sb.pop_front();
      checks += 2;
      if (bus.Instruction !== e.instr) begin
        errors++;
        $display("FAIL seq[%0d] instr: got %h want %h", i, bus.Instruction, e.instr);
      end
      if (bus.PC_Out !== e.pc_out) begin
        errors++;
        $display("FAIL seq[%0d] pc_out: got %h want %h", i, bus.PC_Out, e.pc_out);
      end
    end
  endtask

  task automatic test_edges();
    logic [31:0] pcs [7];
    logic [31:0] ins [7];
    logic [31:0] nxt [7];
    pcs = '{32'h0A, 32'h03, 32'h17, 32'h1C, 32'h100, 32'h3C, 32'hFFFFFFFC};
    ins = '{32'h00222824, 32'h00221820, 32'h00224027, 32'h0, 32'h0, 32'h0, 32'h0};
    nxt = '{32'h0E, 32'h07, 32'h1B, 32'h20, 32'h104, 32'h40, 32'h0};
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, pcs[i], ins[i], nxt[i]);
      e = sb.pop_front();
      checks += 2;
      if (bus.Instruction !== e.instr) begin
        errors++;
        $display("FAIL edge pc=%h instr: got %h want %h", pcs[i], bus.Instruction, e.instr);
      end
      if (bus.PC_Out !== e.pc_out) begin
        errors++;
        $display("FAIL edge pc=%h pc_out: got %h want %h", pcs[i], bus.PC_Out, e.pc_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h0C, 32'h00223025, 32'h10);
    issue(1'b1, 32'h10, 32'h0, 32'h0);
    issue(1'b0, 32'h14, 32'h00224027, 32'h18);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      checks++;
      if (i == 2 && bus.Instruction !== e.instr) begin
        errors++;
        $display("FAIL reset_mid resume: got %h want %h", bus.Instruction, e.instr);
      end
    end
  endtask

  task automatic test_hold();
    issue(1'b0, 32'h04, 32'h00222022, 32'h08);
    e = sb.pop_front();
    bus.PC = 32'h18;
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks += 2;
    if (bus.Instruction !== e.instr) begin
      errors++;
      $display("FAIL hold instr: got %h want %h", bus.Instruction, e.instr);
    end
    if (bus.PC_Out !== e.pc_out) begin
      errors++;
      $display("FAIL hold pc_out: got %h want %h", bus.PC_Out, e.pc_out);
    end
    @(negedge clk);
    bus.PC = 'x;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h18, 32'h00644820, 32'h1C);
    e = sb.pop_front();
    checks++;
    if (bus.Instruction !== e.instr) begin
      errors++;
      $display("FAIL after_x instr: got %h want %h", bus.Instruction, e.instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int i = 0; i < 40; i++) begin
      pc = (i % 4 == 3) ? 32'($urandom) : 32'($urandom_range(0, 80));
      issue(1'b0, pc, model(pc), pc + 32'd4);
      e = sb.pop_front();
      checks += 2;
      if (bus.Instruction !== e.instr) begin
        errors++;
        $display("FAIL b2b pc=%h instr: got %h want %h", pc, bus.Instruction, e.instr);
      end
      if (bus.PC_Out !== e.pc_out) begin
        errors++;
        $display("FAIL b2b pc=%h pc_out: got %h want %h", pc, bus.PC_Out, e.pc_out);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    bus.PC = 32'h0;
    test_reset();
    test_sequential();
    test_edges();
    test_reset_mid();
    test_hold();
    test_back_to_back();
    test_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
